// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side drain engine.
package fifo_rd_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_t;

  localparam int SKID_DEPTH = 2;
  localparam int RD_LATENCY = 1;

  // A new read may issue only if every word already owed to the skid
  // buffer (stored + in flight, minus the one leaving this cycle) still
  // leaves a free slot for it when it lands.
  function automatic logic room_for_read(input logic [1:0] occ,
                                         input logic [1:0] inflight,
                                         input logic       pop);
    logic [2:0] pending;
    pending = {1'b0, occ} + {1'b0, inflight} - {2'b00, pop};
    return pending < 3'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream with burst framing, as driven by fifo_rd_stream.
interface fifo_rd_stream_if #(parameter int WIDTH = 32);
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  modport master (output m_valid, output m_data, output m_last, input  m_ready);
  modport slave  (input  m_valid, input  m_data, input  m_last, output m_ready);
endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order skid buffer; entry 0 is always the head.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       occ
);

  logic [SKID_DEPTH-1:0][WIDTH-1:0] mem;

  assign head = mem[0];

  // Storage and occupancy; entries shift toward the head on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '0;
      occ <= '0;
    end else begin
      case ({wr, pop})
        2'b10: begin
          mem[occ[0]] <= din;
          occ         <= occ + 2'd1;
        end
        2'b01: begin
          mem[0] <= mem[1];
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          // Pop implies occ >= 1, so the new word lands behind the survivor.
          if (occ == 2'd2) begin
            mem[0] <= mem[1];
            mem[1] <= din;
          end else begin
            mem[0] <= din;
          end
        end
        default: ;
      endcase
    end
  end

  a_occ_range:  assert property (@(posedge clk) disable iff (rst) occ <= 2'd2);
  a_no_overrun: assert property (@(posedge clk) disable iff (rst) !(wr && !pop && occ == 2'd2));
  a_no_underrun: assert property (@(posedge clk) disable iff (rst) !(pop && occ == 2'd0));

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side drain engine: issues pops, absorbs the registered read
// latency in a skid buffer and presents a framed valid/ready stream.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_nempty,
  input  logic [WIDTH-1:0]  fifo_data_out,
  output logic              fifo_read_en,
  fifo_rd_stream_if.master  m,
  output logic              busy,
  output logic [CNT_W-1:0]  word_count
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  rd_state_t             state, state_d;
  logic [RD_LATENCY-1:0] rd_pipe;
  logic                  inflight;
  logic [1:0]            occ;
  logic [WIDTH-1:0]      head;
  logic [BEAT_W-1:0]     beat;
  logic                  pop;

  assign inflight = rd_pipe[RD_LATENCY-1];
  assign m.m_valid = (occ != 2'd0);
  assign m.m_data  = head;
  assign m.m_last  = m.m_valid && (beat == LAST_BEAT);
  assign pop       = m.m_valid && m.m_ready;

  fifo_rd_skid #(.WIDTH(WIDTH)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .wr   (inflight),
    .din  (fifo_data_out),
    .pop  (pop),
    .head (head),
    .occ  (occ)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state, read issue and busy; m_ready feeds read issue combinationally
  // so a pop frees its slot in the same cycle and throughput stays 1/cycle.
  always_comb begin
    state_d      = state;
    fifo_read_en = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE:  if (enable) state_d = RUN;
      RUN: begin
        fifo_read_en = fifo_nempty &&
                       room_for_read(occ, 2'($countones(rd_pipe)), pop);
        if (!enable) state_d = DRAIN;
      end
      DRAIN: begin
        if (enable)                             state_d = RUN;
        else if (occ == 2'd0 && !inflight)      state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read-latency tracker: marks which cycle's FIFO output must be captured.
  always_ff @(posedge clk) begin
    if (rst) rd_pipe <= '0;
    else     rd_pipe <= (rd_pipe << 1) | RD_LATENCY'(fifo_read_en);
  end

  // Burst beat position; survives enable drops, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)       beat <= '0;
    else if (pop)  beat <= (beat == LAST_BEAT) ? '0 : beat + BEAT_W'(1);
  end

  // Saturating handshake counter.
  always_ff @(posedge clk) begin
    if (rst)                            word_count <= '0;
    else if (pop && (word_count != '1)) word_count <= word_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized bench for fifo_rd_stream with a queue-based FIFO and a
// timestamped word-delivery reference model.
module tb_fifo_rd_stream;

  localparam int W     = 32;
  localparam int BL    = 8;
  localparam int CW    = 6;
  localparam int MAXWC = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          fifo_nempty;
  logic [W-1:0]  fifo_data_out;
  logic          fifo_read_en;
  logic          busy;
  logic [CW-1:0] word_count;

  fifo_rd_stream_if #(.WIDTH(W)) s_if ();

  fifo_rd_stream #(.WIDTH(W), .BURST_LEN(BL), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .fifo_nempty   (fifo_nempty),
    .fifo_data_out (fifo_data_out),
    .fifo_read_en  (fifo_read_en),
    .m             (s_if.master),
    .busy          (busy),
    .word_count    (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Reference model: every word popped from the FIFO becomes deliverable
  // two cycles later and leaves in order on a handshake.
  typedef struct {
    logic [W-1:0] d;
    int           avail;
  } word_t;

  word_t        wq[$];
  logic [W-1:0] fq[$];
  int           cyc    = 0;
  bit           run_m  = 0;
  bit           busy_m = 0;
  int           hs     = 0;
  int           wc_m   = 0;
  bit           pend   = 0;
  logic [W-1:0] pend_d = '0;

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) fq.push_back($urandom);
  endtask

  task automatic step(input bit r, input bit e, input bit rd);
    bit    vld_e, pop_e, rden_e;
    int    outst;
    word_t w;
    @(negedge clk);
    rst          = r;
    enable       = e;
    s_if.m_ready = rd;
    fifo_nempty  = (fq.size() != 0);
    fifo_data_out = pend ? pend_d : W'($urandom);
    pend = 0;
    #1;
    outst  = wq.size();
    vld_e  = (outst > 0) && (wq[0].avail <= cyc);
    pop_e  = vld_e && rd;
    rden_e = run_m && fifo_nempty && ((outst - int'(pop_e)) < 2);
    chk("m_valid",    s_if.m_valid, vld_e);
    chk("rd_en",      fifo_read_en, rden_e);
    chk("busy",       busy, busy_m);
    chk("word_count", word_count, wc_m);
    chk("m_last",     s_if.m_last, vld_e && (hs % BL == BL - 1));
    if (vld_e) chk("m_data", s_if.m_data, wq[0].d);
    if (r) begin
      wq.delete();
      hs = 0; wc_m = 0; busy_m = 0; run_m = 0;
    end else begin
      if (pop_e) begin
        void'(wq.pop_front());
        hs++;
        if (wc_m < MAXWC) wc_m++;
      end
      busy_m = e || run_m || (busy_m && outst > 0);
      run_m  = e;
    end
    if (fifo_read_en === 1'b1 && fq.size() > 0) begin
      pend_d = fq.pop_front();
      pend   = 1;
      if (!r) begin
        w.d = pend_d; w.avail = cyc + 2;
        wq.push_back(w);
      end
    end
    cyc++;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; fifo_nempty = 1'b0; fifo_data_out = '0;
    s_if.m_ready = 1'b0;
    @(posedge clk);

    // Reset held two cycles.
    repeat (2) step(1, 0, 0);
    step(0, 0, 0);
    chk("rst_m_data", s_if.m_data, '0);

    // Preloaded 0..15, full-rate stream.
    for (int i = 0; i < 16; i++) fq.push_back(W'(i));
    repeat (22) step(0, 1, 1);
    chk("t2_wc", word_count, 16);
    repeat (3) step(0, 0, 1);
    chk("t2_idle", busy, 0);

    // Backpressure mid-stream.
    push_rand(12);
    repeat (4) step(0, 1, 1);
    repeat (5) step(0, 1, 0);
    repeat (20) step(0, 1, 1);

    // Underrun: 3 words, starve, then 2 more.
    step(1, 0, 0);
    push_rand(3);
    repeat (8) step(0, 1, 1);
    chk("t4_valid", s_if.m_valid, 0);
    chk("t4_busy",  busy, 1);
    push_rand(2);
    repeat (6) step(0, 1, 1);

    // Disable mid-stream: drains buffered words then goes idle.
    push_rand(10);
    repeat (5) step(0, 1, 1);
    repeat (10) step(0, 0, 1);
    chk("t5_idle", busy, 0);

    // Reset mid-burst, restart framing from zero.
    step(1, 0, 1);
    fq.delete();
    push_rand(12);
    repeat (7) step(0, 1, 1);
    step(1, 1, 1);
    step(0, 1, 1);
    chk("t6_valid", s_if.m_valid, 0);
    push_rand(10);
    repeat (20) step(0, 1, 1);

    // Random traffic without reset; counter must saturate.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) push_rand($urandom_range(1, 3));
      step(0, $urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0);
    end
    chk("wc_sat", word_count, MAXWC);

    // Random traffic with occasional reset.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) push_rand($urandom_range(1, 3));
      step($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
